mem_stage_access_unit: RTL and testbench
========================================

# mem_stage_access_unit

Memory-stage consumer of the EX/MEM pipeline latch outputs: takes the latched ALU result/address, store data, one-hot destination select, load/store flag and NOP bit, and performs the data-memory access via a req/ack handshake. It registers the writeback result for the MEM/WB latch. While an access is outstanding it raises a stall that freezes the upstream latches. A timeout counter guards against a non-responding memory.

## Interface
- `TIMEOUT_CYCLES`, default 64: max cycles `memReq` is held without `memAck` before abort (≥2)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `dbusWire3` in 64: ALU result; memory address for load/store
- `bbusWire4` in 64: store data
- `DselectWire4` in 32: one-hot destination register select (all-zero = no write)
- `lwSwFlag4` in 2: 2'b01 load, 2'b10 store, 2'b00 ALU op, 2'b11 reserved
- `NOPWire3` in 1: instruction is a bubble
- `memAck` in 1: memory completes access this cycle
- `memRdata` in 64: load data, valid when `memAck`=1
- `memReq` out 1: access request, registered
- `memWe` out 1: 1 = write, registered, valid with `memReq`
- `memAddr` out 64: registered address
- `memWdata` out 64: registered store data
- `stall` out 1: combinational; upstream latches hold when 1
- `wbData` out 64: registered writeback data
- `wbDselect` out 32: registered one-hot destination
- `wbValid` out 1: registered; writeback performs a register write
- `memErr` out 1: sticky timeout flag, cleared only by reset

## Operation
- States: IDLE, ACCESS.
- IDLE, `NOPWire3`=1 or `lwSwFlag4`=2'b11: next cycle `wbValid`=0, `wbDselect`=0, `wbData`=0; no access.
- IDLE, ALU op (flag 00, not NOP): next cycle `wbData`=`dbusWire3`, `wbDselect`=`DselectWire4`, `wbValid`=|`DselectWire4`.
- IDLE, load/store (not NOP): capture address, store data, dselect, and flag. Go to ACCESS with `memReq`=1, `memWe`=(flag==10). Next cycle `wbValid`=0.
- ACCESS: `memReq`, `memWe`, `memAddr`, `memWdata` are held constant; inputs are ignored.
- ACCESS, `memAck`=1: go to IDLE and drop `memReq` on the same edge.
  - Load: `wbData`=`memRdata`, `wbDselect`=captured dselect, `wbValid`=|dselect.
  - Store: `wbValid`=0, `wbDselect`=0.
- ACCESS, counter reaches `TIMEOUT_CYCLES` without ack: drop `memReq`, set `memErr`=1, set `wbValid`=0, go to IDLE.
- The counter clears on entry to ACCESS. A `memAck` in the timeout cycle wins: normal completion, no error.
- `memAck` in IDLE is ignored.
- `stall` = (IDLE & load/store & !NOP) | (ACCESS & !`memAck` & !timeout).

## Timing
- Reset values: state IDLE; `memReq`, `memWe`, `memErr`, `wbValid` = 0; `memAddr`, `memWdata`, `wbData`, `wbDselect` = 0; counter 0.
- ALU/NOP latency: 1 cycle, no stall.
- Load/store latency:
  - Issue at edge N; `memReq` high from N+1.
  - Ack sampled at edge N+k (k≥1); writeback visible after N+k.
  - Minimum 2 cycles.
- The upstream latch advances on the edge where the ack is taken, because `stall` is low in that cycle. The next instruction is therefore presented in IDLE with no double issue.
- Back-to-back loads: a new `memReq` rises one cycle after the previous ack. There is one `memReq`-low cycle between accesses.
- Reset asserted in ACCESS: `memReq` low and state IDLE after the next edge; the pending access is abandoned.

## Structure
- Shared package `mem_stage_pkg`: `LWSW_NONE`/`LWSW_LOAD`/`LWSW_STORE`/`LWSW_RSVD` constants and the state enum `{IDLE, ACCESS}`.
- One sub-module is natural: `mem_timeout_counter`. It has clear, enable, and terminal-count output, with width $clog2(`TIMEOUT_CYCLES`+1).

## Test plan
- ALU op, `dbusWire3`=64'h1234, `DselectWire4`=32'h0000_0008 → next cycle `wbData`=64'h1234, `wbValid`=1, `stall` never high.
- Load with `dbusWire3`=64'h100, dselect bit 5, memory acks on 3rd `memReq` cycle with `memRdata`=64'hDEAD_BEEF. Expected:
  - `memReq` high exactly 3 cycles and `memAddr`=64'h100.
  - `stall` high 3 cycles.
  - `wbData`=64'hDEAD_BEEF and `wbDselect`=32'h20 after the ack edge.
- Store with `bbusWire4`=64'hA5A5, ack same cycle as `memReq` → `memWe`=1, `memWdata`=64'hA5A5, `wbValid`=0, one `memReq` cycle.
- Load with no ack, `TIMEOUT_CYCLES`=4 → `memReq` high 4 cycles then low, `memErr`=1 sticky across later ops until `reset`.
- `NOPWire3`=1 with `lwSwFlag4`=2'b01 → no `memReq`, `wbValid`=0. Then `reset` pulsed mid-ACCESS → `memReq`=0 and all outputs at reset values next cycle.
- Two back-to-back loads with immediate ack → second `memReq` rises exactly one cycle after the first ack, and both writebacks appear in order.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and state type for the memory-stage access unit.
package mem_stage_pkg;

    localparam int DATA_W = 64;
    localparam int DSEL_W = 32;

    localparam logic [1:0] LWSW_NONE  = 2'b00;
    localparam logic [1:0] LWSW_LOAD  = 2'b01;
    localparam logic [1:0] LWSW_STORE = 2'b10;
    localparam logic [1:0] LWSW_RSVD  = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic isMemOp(input logic [1:0] flag, input logic nop);
        return !nop && (flag == LWSW_LOAD || flag == LWSW_STORE);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles an access has been outstanding; flags the last allowed cycle.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // High during the TIMEOUT_CYCLES-th enabled cycle since the last clear.
    assign terminal = enable && (count == LAST);

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM stage: ALU passthrough to writeback, or a req/ack data-memory access
// that stalls the upstream latches until ack or timeout.
module mem_stage_access_unit
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dbusWire3,
    input  logic [DATA_W-1:0] bbusWire4,
    input  logic [DSEL_W-1:0] DselectWire4,
    input  logic [1:0]        lwSwFlag4,
    input  logic              NOPWire3,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRdata,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic              stall,
    output logic [DATA_W-1:0] wbData,
    output logic [DSEL_W-1:0] wbDselect,
    output logic              wbValid,
    output logic              memErr
);

    state_t            state;
    logic [DSEL_W-1:0] capDsel;
    logic              capStore;
    logic              issue;
    logic              timeout;

    assign issue = (state == IDLE) && isMemOp(lwSwFlag4, NOPWire3);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uTimeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (issue),
        .enable  (state == ACCESS),
        .terminal(timeout)
    );

    // Low in the completing cycle so the upstream latch advances on that edge.
    assign stall = issue || ((state == ACCESS) && !memAck && !timeout);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memWdata  <= '0;
            memErr    <= 1'b0;
            wbData    <= '0;
            wbDselect <= '0;
            wbValid   <= 1'b0;
            capDsel   <= '0;
            capStore  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state     <= ACCESS;
                        memReq    <= 1'b1;
                        memWe     <= (lwSwFlag4 == LWSW_STORE);
                        memAddr   <= dbusWire3;
                        memWdata  <= bbusWire4;
                        capDsel   <= DselectWire4;
                        capStore  <= (lwSwFlag4 == LWSW_STORE);
                        wbValid   <= 1'b0;
                        wbDselect <= '0;
                    end else if (!NOPWire3 && lwSwFlag4 == LWSW_NONE) begin
                        wbData    <= dbusWire3;
                        wbDselect <= DselectWire4;
                        wbValid   <= |DselectWire4;
                    end else begin
                        wbData    <= '0;
                        wbDselect <= '0;
                        wbValid   <= 1'b0;
                    end
                end
                ACCESS: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (memAck) begin
                        state  <= IDLE;
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                        if (capStore) begin
                            wbValid   <= 1'b0;
                            wbDselect <= '0;
                        end else begin
                            wbData    <= memRdata;
                            wbDselect <= capDsel;
                            wbValid   <= |capDsel;
                        end
                    end else if (timeout) begin
                        state     <= IDLE;
                        memReq    <= 1'b0;
                        memWe     <= 1'b0;
                        memErr    <= 1'b1;
                        wbValid   <= 1'b0;
                        wbDselect <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Scoreboard bench: driver issues instructions through the stall handshake,
// a memory responder acks after chosen delays, monitors pop expected results.
module tb_mem_stage_access_unit;
    import mem_stage_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] dbusWire3 = '0;
    logic [63:0] bbusWire4 = '0;
    logic [31:0] DselectWire4 = '0;
    logic [1:0]  lwSwFlag4 = 2'b00;
    logic        NOPWire3 = 1'b1;
    logic        memAck = 1'b0;
    logic [63:0] memRdata = '0;
    logic        memReq, memWe, stall, wbValid, memErr;
    logic [63:0] memAddr, memWdata, wbData;
    logic [31:0] wbDselect;

    mem_stage_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .dbusWire3(dbusWire3), .bbusWire4(bbusWire4),
        .DselectWire4(DselectWire4), .lwSwFlag4(lwSwFlag4), .NOPWire3(NOPWire3),
        .memAck(memAck), .memRdata(memRdata), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWdata(memWdata), .stall(stall), .wbData(wbData),
        .wbDselect(wbDselect), .wbValid(wbValid), .memErr(memErr)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] data;
        logic [31:0] dsel;
    } wb_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        int          delay;
        int          expLen;
    } acc_t;

    wb_t  wbQ[$];
    acc_t accQ[$];
    logic [63:0] refMem[logic [63:0]];
    logic [63:0] physMem[logic [63:0]];
    bit   errExp = 1'b0;
    int   lastAckCyc = -100;
    int   lastRiseCyc = -100;
    int   reqLen = 0;
    bit   prevReq = 1'b0;
    acc_t cur;

    function automatic logic [63:0] seedVal(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        nChecks++;
        nFail++;
        $display("FAIL %s: got 1 expected 0", name);
    endtask

    // Memory model and request-side checker.
    always @(negedge clk) begin
        memAck = 1'b0;
        memRdata = {$urandom, $urandom};
        if (memReq) begin
            if (!prevReq) begin
                lastRiseCyc = cyc;
                reqLen = 0;
                if (accQ.size() == 0) begin
                    failNow("unexpected memReq");
                    cur = '{64'h0, 64'h0, 1'b0, 1000, 0};
                end else begin
                    cur = accQ.pop_front();
                end
            end
            reqLen++;
            check("memAddr", memAddr, cur.addr);
            check("memWe", 64'(memWe), 64'(cur.we));
            if (cur.we) check("memWdata", memWdata, cur.wdata);
            if (reqLen == cur.delay) begin
                memAck = 1'b1;
                lastAckCyc = cyc;
                if (cur.we) physMem[memAddr] = memWdata;
                else memRdata = physMem.exists(memAddr) ? physMem[memAddr] : seedVal(memAddr);
            end
        end else if (prevReq) begin
            check("memReq length", 64'(reqLen), 64'(cur.expLen));
        end
        prevReq = memReq;
    end

    // Writeback checker.
    always @(negedge clk) begin
        if (!reset && wbValid) begin
            if (wbQ.size() == 0) begin
                failNow("unexpected wbValid");
            end else begin
                wb_t e;
                e = wbQ.pop_front();
                check("wbData", wbData, e.data);
                check("wbDselect", 64'(wbDselect), 64'(e.dsel));
            end
        end
    end

    task automatic issue(input logic [1:0] flag, input logic nop, input logic [63:0] dbus,
                         input logic [63:0] bbus, input logic [31:0] dsel, input int delay,
                         output int stallCnt);
        acc_t a;
        wb_t  w;
        bit   s;
        int   guard;
        @(negedge clk);
        lwSwFlag4 = flag;
        NOPWire3 = nop;
        dbusWire3 = dbus;
        bbusWire4 = bbus;
        DselectWire4 = dsel;
        if (!nop && (flag == LWSW_LOAD || flag == LWSW_STORE)) begin
            a.addr = dbus;
            a.wdata = bbus;
            a.we = (flag == LWSW_STORE);
            a.delay = delay;
            a.expLen = (delay <= TO) ? delay : TO;
            accQ.push_back(a);
            if (delay > TO) errExp = 1'b1;
            else if (flag == LWSW_STORE) refMem[dbus] = bbus;
            else if (dsel != 0) begin
                w.data = refMem.exists(dbus) ? refMem[dbus] : seedVal(dbus);
                w.dsel = dsel;
                wbQ.push_back(w);
            end
        end else if (!nop && flag == LWSW_NONE && dsel != 0) begin
            w.data = dbus;
            w.dsel = dsel;
            wbQ.push_back(w);
        end
        stallCnt = 0;
        guard = 0;
        forever begin
            #4;
            s = stall;
            if (s) stallCnt++;
            @(posedge clk);
            if (!s) break;
            guard++;
            if (guard > 40) begin
                failNow("stall stuck");
                break;
            end
            @(negedge clk);
        end
        #1;
        check("memErr", 64'(memErr), 64'(errExp));
    endtask

    task automatic setMem(input logic [63:0] addr, input logic [63:0] val);
        refMem[addr] = val;
        physMem[addr] = val;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int ack1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset memReq", 64'(memReq), 64'h0);
        check("reset memWe", 64'(memWe), 64'h0);
        check("reset memErr", 64'(memErr), 64'h0);
        check("reset wbValid", 64'(wbValid), 64'h0);
        check("reset memAddr", memAddr, 64'h0);
        check("reset memWdata", memWdata, 64'h0);
        check("reset wbData", wbData, 64'h0);
        check("reset wbDselect", 64'(wbDselect), 64'h0);
        reset = 1'b0;

        issue(LWSW_NONE, 1'b0, 64'h1234, 64'h0, 32'h0000_0008, 0, sc);
        check("alu stall cycles", 64'(sc), 64'h0);

        setMem(64'h100, 64'hDEAD_BEEF);
        issue(LWSW_LOAD, 1'b0, 64'h100, 64'h0, 32'h20, 3, sc);
        check("load stall cycles", 64'(sc), 64'd3);

        issue(LWSW_STORE, 1'b0, 64'h200, 64'hA5A5, 32'h4, 1, sc);
        check("store stall cycles", 64'(sc), 64'd1);

        issue(LWSW_LOAD, 1'b0, 64'h200, 64'h0, 32'h2, 1, sc);
        ack1 = lastAckCyc;
        issue(LWSW_LOAD, 1'b0, 64'h100, 64'h0, 32'h40, 1, sc);
        check("back-to-back rise gap", 64'(lastRiseCyc - ack1), 64'd2);

        issue(LWSW_LOAD, 1'b1, 64'h100, 64'h0, 32'h8, 1, sc);
        check("nop load stall cycles", 64'(sc), 64'h0);
        issue(LWSW_RSVD, 1'b0, 64'h100, 64'h0, 32'h8, 1, sc);

        issue(LWSW_LOAD, 1'b0, 64'h300, 64'h0, 32'h10, 99, sc);
        check("timeout stall cycles", 64'(sc), 64'd4);
        issue(LWSW_NONE, 1'b0, 64'h55, 64'h0, 32'h1, 0, sc);
        issue(LWSW_LOAD, 1'b0, 64'h100, 64'h0, 32'h1, 2, sc);

        @(negedge clk);
        lwSwFlag4 = LWSW_LOAD;
        NOPWire3 = 1'b0;
        dbusWire3 = 64'h308;
        DselectWire4 = 32'h1;
        accQ.push_back('{64'h308, bbusWire4, 1'b0, 99, 2});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        NOPWire3 = 1'b1;
        @(negedge clk);
        check("rst memReq", 64'(memReq), 64'h0);
        check("rst memWe", 64'(memWe), 64'h0);
        check("rst memErr", 64'(memErr), 64'h0);
        check("rst wbValid", 64'(wbValid), 64'h0);
        check("rst memAddr", memAddr, 64'h0);
        check("rst wbData", wbData, 64'h0);
        check("rst stall", 64'(stall), 64'h0);
        reset = 1'b0;
        errExp = 1'b0;

        for (int i = 0; i < 250; i++) begin
            int kind;
            int d;
            logic [31:0] ds;
            logic [63:0] addr;
            kind = $urandom_range(0, 9);
            d = ($urandom_range(0, 11) == 0) ? $urandom_range(TO + 1, TO + 3) : $urandom_range(1, TO);
            ds = ($urandom_range(0, 3) == 0) ? 32'h0 : (32'(1) << $urandom_range(0, 31));
            addr = 64'($urandom_range(0, 7)) << 3;
            case (kind)
                0: issue(2'($urandom_range(0, 3)), 1'b1, {$urandom, $urandom}, 64'h0, ds, d, sc);
                1: issue(LWSW_RSVD, 1'b0, {$urandom, $urandom}, 64'h0, ds, d, sc);
                2, 3, 4: issue(LWSW_NONE, 1'b0, {$urandom, $urandom}, 64'h0, ds, d, sc);
                5, 6, 7: issue(LWSW_LOAD, 1'b0, addr, 64'h0, ds, d, sc);
                default: issue(LWSW_STORE, 1'b0, addr, {$urandom, $urandom}, ds, d, sc);
            endcase
        end

        issue(LWSW_NONE, 1'b1, 64'h0, 64'h0, 32'h0, 0, sc);
        repeat (3) @(negedge clk);
        check("wb queue drained", 64'(wbQ.size()), 64'h0);
        check("access queue drained", 64'(accQ.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
